// File: rtl/lab6_host_pkg.sv
// lab6_host_pkg: shared types and defaults for the lab6 filter host sequencer.
package lab6_host_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_e;
  localparam int DW_DEF = 10;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_CYC_DEF = 15;
  function automatic int tmo_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction
endpackage

// File: rtl/lab6_sample_fifo.sv
// lab6_sample_fifo: small power-of-2 sample FIFO with registered head pointer.
module lab6_sample_fifo import lab6_host_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  assign cnt_d   = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push_i ? wr_q + 1'b1 : wr_q;
      rd_q  <= pop_i ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/lab6_filter_host.sv
// lab6_filter_host: buffers upstream samples, sequences them one at a time through the
// lab6 three-tap datapath and returns results downstream with a timeout guard.
module lab6_filter_host import lab6_host_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 dp_irdy,
  output logic signed [DW-1:0] dp_din,
  input  logic                 dp_ordy,
  input  logic signed [DW-1:0] dp_dout,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [15:0]          done_count
);
  localparam int TW = tmo_w(TIMEOUT_CYC);
  state_e state_q, state_d;
  logic signed [DW-1:0] din_q, din_d, out_q, out_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [15:0] done_q, done_d;
  logic ov_q, ov_d, err_q, err_d, ordy_q;
  logic full, empty, push, pop, rise, tmo, deliver;
  logic [DW-1:0] head;
  assign push    = in_valid && !full;
  assign pop     = state_q == IDLE && !empty;
  // The datapath signals completion with a rising ordy; the level alone is stale.
  assign rise    = dp_ordy && !ordy_q;
  assign tmo     = cnt_q == TW'(TIMEOUT_CYC - 1);
  assign deliver = state_q == HOLD && out_ready;
  lab6_sample_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .data_i (in_data),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      din_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      ordy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      ordy_q  <= dp_ordy;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    state_d = rise ? HOLD : tmo ? IDLE : BUSY;
      HOLD:    state_d = out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  // Completion takes priority over a timeout landing on the same cycle.
  always_comb begin
    din_d  = pop ? head : din_q;
    cnt_d  = state_q == ISSUE ? '0 : state_q == BUSY ? cnt_q + 1'b1 : cnt_q;
    out_d  = state_q == BUSY && rise ? dp_dout : out_q;
    ov_d   = state_q == BUSY && rise ? 1'b1 : deliver ? 1'b0 : ov_q;
    err_d  = err_q | (state_q == BUSY && !rise && tmo);
    done_d = done_q + 16'(deliver);
  end
  assign in_ready    = !full;
  assign out_valid   = ov_q;
  assign out_data    = out_q;
  assign dp_irdy     = state_q == ISSUE;
  assign dp_din      = din_q;
  assign busy        = state_q != IDLE || !empty;
  assign timeout_err = err_q;
  assign done_count  = done_q;
endmodule
